// File: rtl/servo_u2duty_pkg.sv
// ----------------------------------------------------------------------------
// servo_u2duty_pkg
//
// Shared definitions for the control-effort to PWM-duty converter.
//
// Contents:
//   DUTY_WIDTH_DEFAULT : default width of a signed Q1.15 effort word
//   NUM_CH             : number of independent channels in the wrapper
//   effort_t           : signed Q1.15 effort word (two's complement)
//   duty_t             : unsigned duty count / half-period word
//                        (one bit narrower than the effort)
// ----------------------------------------------------------------------------
package servo_u2duty_pkg;

   localparam int DUTY_WIDTH_DEFAULT = 16;
   localparam int NUM_CH             = 4;

   typedef logic [DUTY_WIDTH_DEFAULT-1:0] effort_t;
   typedef logic [DUTY_WIDTH_DEFAULT-2:0] duty_t;

endpackage : servo_u2duty_pkg

// File: rtl/servo_u2duty_ch.sv
// ----------------------------------------------------------------------------
// servo_u2duty_ch
//
// One channel of the effort-to-duty converter. Splits a signed Q1.15 effort
// into sign and magnitude, scales the magnitude by the PWM half-period and
// drops the Q1.15 fraction bits to obtain an unsigned duty count.
//
//   duty      = floor(|u| * half_period / 2^(DUTY_WIDTH-1))
//   direction = sign of u
//
// Two-stage pipeline, one sample per clock:
//   stage 1 : sign / magnitude of u, half_period captured with its sample
//   stage 2 : multiply, shift, clamp to half_period, register outputs
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-high; clears every register
//   half_period  in   [DUTY_WIDTH-2:0] PWM half-period (full-scale duty)
//   u            in   [DUTY_WIDTH-1:0] signed Q1.15 effort
//   duty         out  [DUTY_WIDTH-2:0] duty count, valid 2 clocks after u
//   direction    out  1 when the matching u sample was negative
// ----------------------------------------------------------------------------
module servo_u2duty_ch
   import servo_u2duty_pkg::*;
#(
   parameter int DUTY_WIDTH = DUTY_WIDTH_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DUTY_WIDTH-2:0] half_period,
   input  logic [DUTY_WIDTH-1:0] u,
   output logic [DUTY_WIDTH-2:0] duty,
   output logic                  direction
);

   localparam int W  = DUTY_WIDTH;
   localparam int PW = 2 * W - 1;   // |u| (W bits) times half_period (W-1 bits)

   // -------------------------------------------------------------------------
   // Stage 1 combinational: sign and magnitude.
   // The magnitude is kept W bits wide so that the most negative effort
   // (e.g. 0x8000) maps to 2^(W-1) instead of wrapping back to itself as a
   // negative number.
   // -------------------------------------------------------------------------
   logic         u_neg;
   logic [W-1:0] u_mag;

   assign u_neg = u[W-1];
   assign u_mag = u_neg ? (-u) : u;

   // -------------------------------------------------------------------------
   // Stage 1 registers
   // -------------------------------------------------------------------------
   logic         sign_s1;
   logic [W-1:0] mag_s1;
   logic [W-2:0] hp_s1;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of its inputs, regardless of block order.
   // NOTE: the data registers are reset too (not only a valid flag), so no
   // sample that was in flight when reset arrived can surface after release.
   always_ff @(posedge clk) begin
      if (reset) begin
         sign_s1 <= 1'b0;
         mag_s1  <= '0;
         hp_s1   <= '0;
      end else begin
         sign_s1 <= u_neg;
         mag_s1  <= u_mag;
         hp_s1   <= half_period;   // travels with its own effort sample
      end
   end

   // -------------------------------------------------------------------------
   // Stage 2 combinational: scale, drop the fraction, clamp.
   // -------------------------------------------------------------------------
   logic [PW-1:0] prod;
   logic          over;
   logic [W-2:0]  duty_next;

   assign prod = PW'(mag_s1) * PW'(hp_s1);

   // The shifted result exceeds hp exactly when prod >= (hp + 1) * 2^(W-1),
   // i.e. when prod is above {hp, all-ones fraction}. Comparing the full
   // product avoids building a separate wide shifted value. With |u| capped
   // at 2^(W-1) this never fires; it guards the output range by construction.
   assign over = prod > {1'b0, hp_s1, {(W-1){1'b1}}};

   // Truncation toward zero: the low W-1 product bits are the Q1.15 fraction.
   assign duty_next = over ? hp_s1 : prod[PW-2:W-1];

   // -------------------------------------------------------------------------
   // Stage 2 registers (outputs)
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         duty      <= '0;
         direction <= 1'b0;
      end else begin
         duty      <= duty_next;
         direction <= sign_s1;
      end
   end

endmodule : servo_u2duty_ch

// File: rtl/servo_u2duty_wrapper.sv
// ----------------------------------------------------------------------------
// servo_u2duty_wrapper
//
// Four-channel converter from signed Q1.15 control efforts to unsigned PWM
// duty counts plus direction bits for a center-aligned PWM / H-bridge stage.
// All channels share one half_period, which is fanned out to every channel
// and therefore affects all of them from the same cycle. Each channel is an
// independent two-stage pipeline: results appear exactly two clocks after
// the inputs are sampled, one result per channel per clock, no handshake.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-high; clears all pipeline state
//   half_period  in   [DUTY_WIDTH-2:0] PWM half-period (full-scale duty)
//   u0..u3       in   [DUTY_WIDTH-1:0] channel efforts, signed Q1.15
//   duty0..duty3 out  [DUTY_WIDTH-2:0] channel duty counts
//   direction    out  [3:0] bit i set when channel i effort was negative
// ----------------------------------------------------------------------------
module servo_u2duty_wrapper
   import servo_u2duty_pkg::*;
#(
   parameter int DUTY_WIDTH = DUTY_WIDTH_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DUTY_WIDTH-2:0] half_period,
   input  logic [DUTY_WIDTH-1:0] u0,
   input  logic [DUTY_WIDTH-1:0] u1,
   input  logic [DUTY_WIDTH-1:0] u2,
   input  logic [DUTY_WIDTH-1:0] u3,
   output logic [DUTY_WIDTH-2:0] duty0,
   output logic [DUTY_WIDTH-2:0] duty1,
   output logic [DUTY_WIDTH-2:0] duty2,
   output logic [DUTY_WIDTH-2:0] duty3,
   output logic [NUM_CH-1:0]     direction
);

   // Channel-indexed views of the flat ports so the channels can be
   // generated in a loop.
   logic [NUM_CH-1:0][DUTY_WIDTH-1:0] u_vec;
   logic [NUM_CH-1:0][DUTY_WIDTH-2:0] duty_vec;
   logic [NUM_CH-1:0]                 dir_vec;

   assign u_vec = {u3, u2, u1, u0};

   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      servo_u2duty_ch #(
         .DUTY_WIDTH (DUTY_WIDTH)
      ) u_ch (
         .clk         (clk),
         .reset       (reset),
         .half_period (half_period),
         .u           (u_vec[ch]),
         .duty        (duty_vec[ch]),
         .direction   (dir_vec[ch])
      );
   end

   assign duty0     = duty_vec[0];
   assign duty1     = duty_vec[1];
   assign duty2     = duty_vec[2];
   assign duty3     = duty_vec[3];
   assign direction = dir_vec;

endmodule : servo_u2duty_wrapper

// File: tb/tb_servo_u2duty_wrapper.sv
// ----------------------------------------------------------------------------
// tb_servo_u2duty_wrapper
//
// Self-checking bench for servo_u2duty_wrapper. Inputs change on the falling
// edge, outputs are sampled on the falling edge. Every rising edge the
// applied inputs are logged; the reference model derives the expected
// outputs from that log using plain integer arithmetic:
//   duty = floor(|u| * hp / 32768), direction = (u < 0),
// taken from the sample two clocks back, or zero if reset was high on either
// of the last two edges.
// ----------------------------------------------------------------------------
module tb_servo_u2duty_wrapper;
   import servo_u2duty_pkg::*;

   logic             clk = 1'b0;
   logic             reset;
   duty_t            half_period;
   logic [3:0][15:0] u;
   duty_t            duty0, duty1, duty2, duty3;
   logic [3:0]       direction;
   logic [3:0][14:0] act;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic             rst;
      logic [14:0]      hp;
      logic [3:0][15:0] u;
   } sample_t;

   sample_t hist[$];

   servo_u2duty_wrapper #(.DUTY_WIDTH(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .half_period (half_period),
      .u0          (u[0]),
      .u1          (u[1]),
      .u2          (u[2]),
      .u3          (u[3]),
      .duty0       (duty0),
      .duty1       (duty1),
      .duty2       (duty2),
      .duty3       (duty3),
      .direction   (direction)
   );

   always #5 clk = ~clk;

   assign act = {duty3, duty2, duty1, duty0};

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no end, want $finish");
      $fatal(1, "watchdog");
   end

   // One clock: log the inputs seen at the rising edge, return at the falling edge.
   task automatic tick();
      @(posedge clk);
      hist.push_back('{rst: reset, hp: half_period, u: u});
      if (hist.size() > 4) void'(hist.pop_front());
      @(negedge clk);
   endtask

   // Reference model: expected outputs right now, plus the hp of that sample.
   function automatic void model(output logic [3:0][14:0] d,
                                 output logic [3:0]       dir,
                                 output logic [14:0]      hp);
      sample_t s;
      d   = '0;
      dir = '0;
      hp  = '0;
      if (hist.size() < 2) return;
      if (hist[$].rst || hist[$-1].rst) return;
      s  = hist[$-1];
      hp = s.hp;
      for (int i = 0; i < 4; i++) begin
         int     v;
         longint m;
         v      = int'($signed(s.u[i]));
         m      = (v < 0) ? -v : v;
         d[i]   = 15'((m * longint'(s.hp)) / 32768);
         dir[i] = (v < 0);
      end
   endfunction

   function automatic logic [15:0] rand_effort();
      int sel;
      sel = $urandom_range(0, 9);
      case (sel)
         0:       return 16'h8000;
         1:       return 16'h7FFF;
         2:       return 16'hFFFF;
         3:       return 16'h0000;
         4:       return 16'h0001;
         default: return 16'($urandom);
      endcase
   endfunction

   function automatic logic [14:0] rand_hp();
      int sel;
      sel = $urandom_range(0, 9);
      case (sel)
         0:       return 15'h0000;
         1:       return 15'h7FFF;
         default: return 15'($urandom_range(0, 32767));
      endcase
   endfunction

   // ------------------------------------------------------------------------
   task automatic test_reset();
      logic [3:0][14:0] exp_d;
      logic [3:0]       exp_dir;
      logic [14:0]      exp_hp;
      reset       = 1'b1;
      half_period = 15'h5A5A;
      for (int i = 0; i < 4; i++) u[i] = 16'h9234 + 16'(i * 16'h1111);
      tick();
      tick();
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (act[i] !== 15'd0) begin
            errors++;
            $display("FAIL reset_duty%0d: got %0d want 0", i, act[i]);
         end
      end
      checks++;
      if (direction !== 4'b0000) begin
         errors++;
         $display("FAIL reset_dir: got %b want 0000", direction);
      end

      reset       = 1'b0;
      half_period = 15'd100;
      u           = '0;
      tick();
      tick();
      model(exp_d, exp_dir, exp_hp);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (act[i] !== 15'd0 || act[i] !== exp_d[i]) begin
            errors++;
            $display("FAIL release_zero_duty%0d: got %0d want 0", i, act[i]);
         end
      end
      checks++;
      if (direction !== 4'b0000 || direction !== exp_dir) begin
         errors++;
         $display("FAIL release_zero_dir: got %b want 0000", direction);
      end
   endtask

   // ------------------------------------------------------------------------
   // Directed boundary vectors with hand-computed results; also checks that
   // the result only appears on the second clock after the input change.
   task automatic test_directed();
      typedef struct packed {
         logic [14:0]      hp;
         logic [3:0][15:0] u;
         logic [3:0][14:0] d;
         logic [3:0]       dir;
      } vec_t;
      vec_t             tbl[6];
      logic [3:0][14:0] prev_d;
      logic [3:0]       prev_dir;

      tbl[0] = '{hp: 15'd100, u: {4{16'hFFFF}}, d: {4{15'd0}},  dir: 4'b1111};
      tbl[1] = '{hp: 15'd100, u: {4{16'h1000}}, d: {4{15'd12}}, dir: 4'b0000};
      tbl[2] = '{hp: 15'd100, u: {4{16'hF000}}, d: {4{15'd12}}, dir: 4'b1111};
      tbl[3] = '{hp: 15'd100,
                 u: {16'h1FF0, 16'hFF00, 16'hF000, 16'h1000},
                 d: {15'd24, 15'd0, 15'd12, 15'd12}, dir: 4'b0110};
      tbl[4] = '{hp: 15'h7FFF,
                 u: {16'h0000, 16'h8000, 16'hFFFF, 16'h7FFF},
                 d: {15'd0, 15'd32767, 15'd0, 15'd32766}, dir: 4'b0110};
      tbl[5] = '{hp: 15'd0,
                 u: {16'h1234, 16'hFFFF, 16'h7FFF, 16'h8000},
                 d: {4{15'd0}}, dir: 4'b0101};

      prev_d   = '0;
      prev_dir = 4'b0000;
      for (int r = 0; r < 6; r++) begin
         half_period = tbl[r].hp;
         u           = tbl[r].u;
         tick();
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (act[i] !== prev_d[i]) begin
               errors++;
               $display("FAIL latency_row%0d_duty%0d: got %0d want %0d", r, i, act[i], prev_d[i]);
            end
         end
         checks++;
         if (direction !== prev_dir) begin
            errors++;
            $display("FAIL latency_row%0d_dir: got %b want %b", r, direction, prev_dir);
         end
         tick();
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (act[i] !== tbl[r].d[i]) begin
               errors++;
               $display("FAIL directed_row%0d_duty%0d: got %0d want %0d", r, i, act[i], tbl[r].d[i]);
            end
         end
         checks++;
         if (direction !== tbl[r].dir) begin
            errors++;
            $display("FAIL directed_row%0d_dir: got %b want %b", r, direction, tbl[r].dir);
         end
         prev_d   = tbl[r].d;
         prev_dir = tbl[r].dir;
      end
   endtask

   // ------------------------------------------------------------------------
   // Back-to-back samples, then reset in the middle of the stream.
   task automatic test_pipeline_reset();
      logic [3:0][14:0] exp_d;
      logic [3:0]       exp_dir;
      logic [14:0]      exp_hp;

      half_period = 15'h7FFF;
      for (int c = 0; c < 13; c++) begin
         // Large magnitudes so a stale sample would show as a non-zero duty.
         for (int i = 0; i < 4; i++) begin
            u[i] = 16'($urandom_range(16'h1000, 16'h7FFF));
            if ($urandom_range(0, 1) == 1) u[i] = -u[i];
         end
         reset = (c == 8);
         tick();
         model(exp_d, exp_dir, exp_hp);
         if (c == 8 || c == 9) begin
            for (int i = 0; i < 4; i++) begin
               checks++;
               if (act[i] !== 15'd0) begin
                  errors++;
                  $display("FAIL reset_flush_c%0d_duty%0d: got %0d want 0", c, i, act[i]);
               end
            end
            checks++;
            if (direction !== 4'b0000) begin
               errors++;
               $display("FAIL reset_flush_c%0d_dir: got %b want 0000", c, direction);
            end
         end else begin
            for (int i = 0; i < 4; i++) begin
               checks++;
               if (act[i] !== exp_d[i]) begin
                  errors++;
                  $display("FAIL stream_c%0d_duty%0d: got %0d want %0d", c, i, act[i], exp_d[i]);
               end
            end
            checks++;
            if (direction !== exp_dir) begin
               errors++;
               $display("FAIL stream_c%0d_dir: got %b want %b", c, direction, exp_dir);
            end
         end
      end
      reset = 1'b0;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_random_sweep();
      logic [3:0][14:0] exp_d;
      logic [3:0]       exp_dir;
      logic [14:0]      exp_hp;

      reset = 1'b0;
      for (int n = 0; n < 10000; n++) begin
         half_period = rand_hp();
         for (int i = 0; i < 4; i++) u[i] = rand_effort();
         tick();
         model(exp_d, exp_dir, exp_hp);
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (act[i] !== exp_d[i]) begin
               errors++;
               $display("FAIL sweep_n%0d_duty%0d: got %0d want %0d", n, i, act[i], exp_d[i]);
            end
            checks++;
            if (act[i] > exp_hp) begin
               errors++;
               $display("FAIL sweep_n%0d_bound%0d: got %0d want <= %0d", n, i, act[i], exp_hp);
            end
         end
         checks++;
         if (direction !== exp_dir) begin
            errors++;
            $display("FAIL sweep_n%0d_dir: got %b want %b", n, direction, exp_dir);
         end
      end
   endtask

   initial begin
      reset       = 1'b1;
      half_period = '0;
      u           = '0;
      @(negedge clk);
      test_reset();
      test_directed();
      test_pipeline_reset();
      test_random_sweep();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_servo_u2duty_wrapper

// File: doc/servo_u2duty_wrapper.md
Name: servo_u2duty_wrapper

Overview:
Converts four signed normalized control efforts (Q1.15, −1..+1) into unsigned PWM duty counts and direction bits for a center-aligned PWM/H-bridge stage (DRV8320 path).
- duty = |u| × half_period / 2^15, truncated.
- direction = sign of u.
- Four identical, independent channels share one half_period.
- Fully pipelined, one result per channel per clock.

Parameters:
DUTY_WIDTH, 16, width of each u input (Q1.15 two's complement); duty/half_period width is DUTY_WIDTH−1.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
half_period  in  DUTY_WIDTH−1  PWM half-period in counts (full-scale duty)
u0  in  DUTY_WIDTH  channel 0 effort, signed Q1.15
u1  in  DUTY_WIDTH  channel 1 effort, signed Q1.15
u2  in  DUTY_WIDTH  channel 2 effort, signed Q1.15
u3  in  DUTY_WIDTH  channel 3 effort, signed Q1.15
duty0  out  DUTY_WIDTH−1  channel 0 duty count
duty1  out  DUTY_WIDTH−1  channel 1 duty count
duty2  out  DUTY_WIDTH−1  channel 2 duty count
duty3  out  DUTY_WIDTH−1  channel 3 duty count
direction  out  4  bit i = 1 when ui is negative

Interface rule: one clock; reset is synchronous and active-high.

Behaviour:
- Reset: duty0..3 = 0 and direction = 4'b0000 on the first clock edge with reset high. All pipeline registers clear. Reset takes priority over data at any time; in-flight results are discarded.
- Stage 1 (edge k):
  - sign_i = ui[MSB].
  - mag_i = sign ? −ui : ui, as an unsigned DUTY_WIDTH-bit value; 0x8000 gives mag 32768.
  - half_period is registered alongside, so each sample pairs with its own half_period.
- Stage 2 (edge k+1):
  - prod = mag_i × hp, unsigned, 2·DUTY_WIDTH−1 bits.
  - duty_i = prod >> (DUTY_WIDTH−1), truncated toward zero, no rounding.
  - Clamp duty_i to hp; the clamp activates only if the math exceeds hp. Since mag ≤ 2^15, duty ≤ hp always holds.
  - direction[i] = registered sign_i.
- Latency: exactly 2 clocks from input sample to output. Throughput: 1 sample per clock per channel. No handshake.
- Boundaries:
  - u = 0 → duty 0, dir 0.
  - u = 0xFFFF (−1 LSB) → duty 0, dir 1.
  - u = 0x8000 → duty = hp, dir 1.
  - u = 0x7FFF → duty = floor(32767·hp/32768).
  - hp = 0 → all duties 0; direction still tracks sign.
- Channels are fully independent; a changing half_period affects all channels from the same cycle.

Decomposition:
- Shared package: DUTY_WIDTH default, NUM_CH = 4 constant, duty_t and effort_t typedefs.
- Sub-module servo_u2duty_ch (one channel: abs/sign, multiply, shift, clamp, 2-stage pipeline), instantiated 4×.
- Wrapper fans out half_period and packs the direction bits.

Test Plan:
1. Reset high for 2 clocks with any inputs → all duty = 0, direction = 0000. Then release, hp=100, u*=0 → duty 0, dir 0000 after 2 clocks.
2. hp=100, u0..3=0xFFFF → duty 0, direction 1111. Then u*=0x1000 → duty 12, dir 0000. Then u*=0xF000 → duty 12, dir 1111. Each result appears exactly 2 clocks after the input change.
3. hp=100, u0=0x1000, u1=0xF000, u2=0xFF00, u3=0x1FF0 → duty0=12, duty1=12, duty2=0, duty3=24, direction=4'b0110.
4. hp=0x7FFF, u0=0x7FFF, u1=0xFFFF, u2=0x8000, u3=0x0000 → duty0=32766, duty1=0, duty2=32767, duty3=0, direction=4'b0110.
5. Pipeline/reset: change u every clock for 8 clocks, then assert reset mid-stream → outputs match a golden model delayed 2 cycles. With reset high, outputs are 0 on the next edge and no stale value appears after release.
6. Random sweep of u and hp (10k vectors) vs reference floor(|u|·hp/32768) with sign → exact match, and duty ≤ hp on every cycle.
